// File: rtl/swr_seq_pkg.sv
// Shared types and defaults for the software-reset sequencer (swr_seq).
// The optional completion timeout is enabled with SWR_SEQ_TIMEOUT_EN.
package swr_seq_pkg;

    // Width of the encoded sequencer state
    localparam int unsigned STATE_W = 3;

    // Width of the rstsoft pulse-length counter
    localparam int unsigned PCNT_W = 4;

    // Default parameter values for swr_seq
    localparam int unsigned PULSE_LEN_DEF = 4;
    localparam int unsigned TMO_W_DEF     = 10;
    localparam int unsigned TMO_MAX_DEF   = 1023;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        ASSERT  = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        DONE    = 3'd4
    } swr_state_e;

endpackage

// File: rtl/swr_seq_sync2.sv
// Generic 2-flop synchroniser, async active-low reset, resets to 0.
module swr_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of an asynchronous level into the local clock domain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/swr_seq.sv
// Software-reset sequencer in the CSR clock domain.
// A host write of SWR=1 launches a PULSE_LEN-cycle rstsoft request, then the
// sequencer waits for hrstn and rrstn to be seen low and then both high again.
// Optional feature macro: SWR_SEQ_TIMEOUT_EN adds the completion timeout and
// the sticky swr_tmo flag; without it the WAIT states wait indefinitely.
//
// Handshake: swr_wr is a single-cycle strobe with no back-pressure; a write
// with swr_wdata=1 is accepted only while the sequencer is IDLE, every other
// write is dropped silently. swr_busy is the readback of an accepted request.
module swr_seq
    import swr_seq_pkg::*;
#(
    parameter int unsigned PULSE_LEN = PULSE_LEN_DEF
`ifdef SWR_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TMO_W     = TMO_W_DEF,
    parameter int unsigned TMO_MAX   = TMO_MAX_DEF
`endif
) (
    input  logic               clkcsr,
    input  logic               rstcsrn,
    input  logic               swr_wr,
    input  logic               swr_wdata,
    input  logic               hrstn,
    input  logic               rrstn,
    output logic               rstsoft,
    output logic               swr_busy,
    output logic               swr_done,
    output logic               swr_tmo,
    output logic [STATE_W-1:0] swr_state_dbg
);

    localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(PULSE_LEN - 1);

    swr_state_e        state_q, state_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              hlo_q, hlo_d;
    logic              rlo_q, rlo_d;
    logic              hs;
    logic              rs;

`ifdef SWR_SEQ_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TCNT_LAST = TMO_W'(TMO_MAX - 1);
    localparam logic [TMO_W-1:0] TCNT_SAT  = TMO_W'(TMO_MAX);

    logic [TMO_W-1:0] tcnt_q, tcnt_d;
    logic             tmo_q, tmo_d;
`endif

    swr_sync2 u_sync_h (
        .clk_i  (clkcsr),
        .rst_ni (rstcsrn),
        .d_i    (hrstn),
        .q_o    (hs)
    );

    swr_sync2 u_sync_r (
        .clk_i  (clkcsr),
        .rst_ni (rstcsrn),
        .d_i    (rrstn),
        .q_o    (rs)
    );

    // State, pulse counter, low-seen latches and timeout registers
    always_ff @(posedge clkcsr or negedge rstcsrn) begin
        if (!rstcsrn) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            hlo_q   <= 1'b0;
            rlo_q   <= 1'b0;
`ifdef SWR_SEQ_TIMEOUT_EN
            tcnt_q  <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            hlo_q   <= hlo_d;
            rlo_q   <= rlo_d;
`ifdef SWR_SEQ_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Next-state logic; the timeout override is applied after the normal
    // transitions so that a same-cycle completion (DONE) takes priority
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        hlo_d   = hlo_q;
        rlo_d   = rlo_q;
`ifdef SWR_SEQ_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (swr_wr && swr_wdata) begin
                    state_d = ASSERT;
                    pcnt_d  = PCNT_LOAD;
`ifdef SWR_SEQ_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                end
            end
            ASSERT: begin
                if (pcnt_q == '0) begin
                    state_d = WAIT_LO;
                    hlo_d   = 1'b0;
                    rlo_d   = 1'b0;
`ifdef SWR_SEQ_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end else begin
                    pcnt_d = pcnt_q - 1'b1;
                end
            end
            WAIT_LO: begin
                // Each domain's low is remembered on its own; they need not overlap
                hlo_d = hlo_q | ~hs;
                rlo_d = rlo_q | ~rs;
                if (hlo_d && rlo_d) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (hs && rs) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef SWR_SEQ_TIMEOUT_EN
        if (state_q == WAIT_LO || state_q == WAIT_HI) begin
            if (tcnt_q != TCNT_SAT) begin
                tcnt_d = tcnt_q + 1'b1;
            end
            // This is the TMO_MAX-th wait cycle: give up unless completing now
            if (tcnt_q == TCNT_LAST && state_d != DONE) begin
                state_d = IDLE;
                tmo_d   = 1'b1;
            end
        end
`endif
    end

    assign rstsoft       = (state_q == ASSERT);
    assign swr_busy      = (state_q != IDLE);
    assign swr_done      = (state_q == DONE);
    assign swr_state_dbg = state_q;
`ifdef SWR_SEQ_TIMEOUT_EN
    assign swr_tmo       = tmo_q;
`else
    assign swr_tmo       = 1'b0;
`endif

endmodule

// File: tb/tb_swr_seq.sv
// Self-checking bench for swr_seq.
// Builds with or without SWR_SEQ_TIMEOUT_EN; the timeout scenario adapts.
module tb_swr_seq;

    localparam int PULSE_LEN = 4;
    localparam int TMO_MAX   = 1023;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       swr_wr    = 1'b0;
    logic       swr_wdata = 1'b0;
    logic       hrstn     = 1'b1;
    logic       rrstn     = 1'b1;
    logic       rstsoft;
    logic       swr_busy;
    logic       swr_done;
    logic       swr_tmo;
    logic [2:0] swr_state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    swr_seq dut (
        .clkcsr        (clk),
        .rstcsrn       (rst_n),
        .swr_wr        (swr_wr),
        .swr_wdata     (swr_wdata),
        .hrstn         (hrstn),
        .rrstn         (rrstn),
        .rstsoft       (rstsoft),
        .swr_busy      (swr_busy),
        .swr_done      (swr_done),
        .swr_tmo       (swr_tmo),
        .swr_state_dbg (swr_state_dbg)
    );

    // ---------------- comparison helper ----------------
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Timestamp view of a request: accepted at cycle m_start, rstsoft for
    // PULSE_LEN cycles, then the wait window; synchronised inputs are the
    // raw inputs delayed by two clocks. Expected {rstsoft,busy,done,tmo}.
    logic [3:0] exp_q[$];
    bit         m_active, m_tmo, m_lows, m_h_seen, m_r_seen;
    int         m_start, m_done_at;
    logic [1:0] h_sh, r_sh;
    bit         hs_p, rs_p;
    int         p;

    initial begin
        m_active = 0; m_tmo = 0; m_lows = 0; m_h_seen = 0; m_r_seen = 0;
        m_start = 0; m_done_at = -1; h_sh = '0; r_sh = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 0; m_tmo = 0; m_done_at = -1; h_sh = '0; r_sh = '0;
                exp_q.delete();
                exp_q.push_back(4'b0000);
            end else begin
                cyc++;
                p    = cyc - 1;
                hs_p = h_sh[1];
                rs_p = r_sh[1];
                h_sh = {h_sh[0], hrstn};
                r_sh = {r_sh[0], rrstn};
                if (!m_active) begin
                    if (swr_wr && swr_wdata) begin
                        m_active = 1; m_tmo = 0; m_start = cyc; m_done_at = -1;
                        m_lows = 0; m_h_seen = 0; m_r_seen = 0;
                    end
                end else if (m_done_at >= 0) begin
                    if (cyc == m_done_at + 1) m_active = 0;
                end else if (p >= m_start + PULSE_LEN) begin
                    if (!m_lows) begin
                        if (!hs_p) m_h_seen = 1;
                        if (!rs_p) m_r_seen = 1;
                        m_lows = m_h_seen && m_r_seen;
                    end else if (hs_p && rs_p) begin
                        m_done_at = cyc;
                    end
`ifdef SWR_SEQ_TIMEOUT_EN
                    if (m_done_at < 0 && (p - (m_start + PULSE_LEN) + 1) >= TMO_MAX) begin
                        m_active = 0;
                        m_tmo    = 1;
                    end
`endif
                end
                exp_q.push_back({m_active && m_done_at < 0 && cyc < m_start + PULSE_LEN,
                                 m_active,
                                 m_active && cyc == m_done_at,
                                 m_tmo});
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    int  hi_cnt, rise_cnt, done_cnt, busy_cycles, rise_cyc, done_cyc;
    bit  rs_prev = 0;
    logic [3:0] e;

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rstsoft", rstsoft, e[3]);
                check("swr_busy", swr_busy, e[2]);
                check("swr_done", swr_done, e[1]);
                check("swr_tmo", swr_tmo, e[0]);
            end
            if (rstsoft) hi_cnt++;
            if (rstsoft && !rs_prev) begin rise_cnt++; rise_cyc = cyc; end
            rs_prev = rstsoft;
            if (swr_done) begin done_cnt++; done_cyc = cyc; end
            if (swr_busy) busy_cycles++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic request(input logic wd);
        swr_wr    = 1'b1;
        swr_wdata = wd;
        step(1);
        swr_wr    = 1'b0;
        swr_wdata = 1'b0;
    endtask

    task automatic clear_stats();
        hi_cnt = 0; rise_cnt = 0; done_cnt = 0; busy_cycles = 0;
        rise_cyc = 0; done_cyc = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (swr_busy && n < budget) begin
            step(1);
            n++;
        end
        check(name, swr_busy, 1'b0);
    endtask

    task automatic drop_both();
        hrstn = 1'b0;
        rrstn = 1'b0;
    endtask

    task automatic raise_both();
        hrstn = 1'b1;
        rrstn = 1'b1;
    endtask

    // Watchdog: the run must end on its own
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        rst_n = 1'b0;
        step(3);
        check("reset_rstsoft", rstsoft, 1'b0);
        check("reset_busy", swr_busy, 1'b0);
        check("reset_done", swr_done, 1'b0);
        check("reset_tmo", swr_tmo, 1'b0);
        check("reset_state", swr_state_dbg, 32'(swr_seq_pkg::IDLE));
        rst_n = 1'b1;
        step(3);

        // T1 nominal, plus a write landing in the DONE cycle
        clear_stats();
        request(1'b1);
        step(3);
        drop_both();
        step(20);
        raise_both();
        step(3);
        check("t1_done_now", swr_done, 1'b1);
        request(1'b1);
        step(5);
        check("t1_pulse_len", hi_cnt, 4);
        check("t1_rise_cnt", rise_cnt, 1);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_rise_to_done", done_cyc - rise_cyc, 26);
        check("t1_busy_cycles", busy_cycles, 27);
        check("t1_tmo", swr_tmo, 1'b0);
        check("t1_idle", swr_busy, 1'b0);

        // T2 staggered, non-overlapping lows
        clear_stats();
        request(1'b1);
        step(5);
        hrstn = 1'b0;
        step(3);
        hrstn = 1'b1;
        step(3);
        rrstn = 1'b0;
        step(3);
        rrstn = 1'b1;
        wait_idle("t2_idle", 40);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_rise_to_done", done_cyc - rise_cyc, 17);

        // T3 / T6 no reset activity from the domains
        clear_stats();
        request(1'b1);
`ifdef SWR_SEQ_TIMEOUT_EN
        wait_idle("t3_idle", 1100);
        check("t3_tmo_set", swr_tmo, 1'b1);
        check("t3_done_cnt", done_cnt, 0);
        check("t3_busy_cycles", busy_cycles, 1027);
        clear_stats();
        request(1'b1);
        check("t3_tmo_cleared", swr_tmo, 1'b0);
        check("t3_busy_again", swr_busy, 1'b1);
        step(5);
        drop_both();
        step(3);
        raise_both();
        wait_idle("t3_idle2", 30);
        check("t3_done_cnt2", done_cnt, 1);
        check("t3_tmo_after", swr_tmo, 1'b0);
`else
        step(1200);
        check("t6_busy_held", swr_busy, 1'b1);
        check("t6_tmo_zero", swr_tmo, 1'b0);
        check("t6_done_cnt", done_cnt, 0);
        check("t6_state", swr_state_dbg, 32'(swr_seq_pkg::WAIT_LO));
        drop_both();
        step(3);
        raise_both();
        wait_idle("t6_idle", 30);
        check("t6_done_cnt2", done_cnt, 1);
`endif

        // T4 write while busy (WAIT_HI) and zero write while idle
        clear_stats();
        request(1'b1);
        step(5);
        drop_both();
        step(5);
        check("t4_in_wait_hi", swr_state_dbg, 32'(swr_seq_pkg::WAIT_HI));
        request(1'b1);
        step(3);
        raise_both();
        wait_idle("t4_idle", 30);
        check("t4_rise_cnt", rise_cnt, 1);
        check("t4_done_cnt", done_cnt, 1);
        clear_stats();
        request(1'b0);
        step(3);
        check("t4_zero_busy", swr_busy, 1'b0);
        check("t4_zero_rise", rise_cnt, 0);
        check("t4_zero_state", swr_state_dbg, 32'(swr_seq_pkg::IDLE));

        // T5 reset in the second ASSERT cycle
        clear_stats();
        request(1'b1);
        step(1);
        rst_n = 1'b0;
        #1;
        check("t5_async_rstsoft", rstsoft, 1'b0);
        check("t5_async_busy", swr_busy, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("t5_state_idle", swr_state_dbg, 32'(swr_seq_pkg::IDLE));
        check("t5_busy_idle", swr_busy, 1'b0);
        clear_stats();
        request(1'b1);
        step(3);
        drop_both();
        step(20);
        raise_both();
        wait_idle("t5_idle", 20);
        check("t5_pulse_len", hi_cnt, 4);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_rise_to_done", done_cyc - rise_cyc, 26);

        step(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
